f_fetch_seq: RTL and testbench

//  Fetch-stage PC sequencer for the P7 pipeline. Owns the fetch PC and runs a single-outstanding
//  req/gnt/rvalid handshake to instruction memory. Picks the next fetch address by priority:

---
 rtl/f_fetch_seq_if.sv | 24 ++
 rtl/f_fetch_seq.sv | 179 +++++++++++++++++
 tb/tb_f_fetch_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/f_fetch_seq_if.sv
// rtl/f_fetch_seq_if.sv - instruction-memory req/gnt/rvalid bus between fetch sequencer and imem
interface f_fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/f_fetch_seq.sv
// rtl/f_fetch_seq.sv - fetch-stage PC sequencer with single-outstanding imem handshake
module f_fetch_seq #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO      = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI      = 32'h0000_6ffc
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          exc_req,
  input  logic          eret,
  input  logic [31:0]   epc,
  input  logic          redir_valid,
  input  logic [31:0]   redir_pc,
  f_fetch_seq_if.master imem,
  output logic          f_valid,
  output logic [31:0]   f_pc,
  output logic [31:0]   f_instr,
  output logic          f_exc_adel
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] addr_q;   // current request while in S_REQ, next fetch address otherwise
  logic [31:0] cur_pc;   // address of the request currently in flight
  logic [31:0] pend_pc;  // redirect or flush target waiting for the current request to be granted
  logic        pend_v;
  logic        kill;     // in-flight response belongs to a flushed path

  logic        flush;
  logic [31:0] flush_pc;
  logic        redir;
  logic [31:0] seq_pc;

  function automatic logic fetch_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
  endfunction

  // Flush sources: an exception acts regardless of stall; eret only when D advances.
  assign flush    = exc_req | (eret & ~stall);
  assign flush_pc = exc_req ? HANDLER_ADDR : epc;

  // While a kill is pending D only holds wrong-path work, so its redirects are ignored.
  assign redir    = redir_valid & ~stall & ~exc_req & ~eret & ~kill;

  // Address following the request being issued now: a same-cycle redirect wins over a queued one.
  assign seq_pc   = redir ? redir_pc : (pend_v ? pend_pc : addr_q + 32'd4);

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // Fetch FSM: request, wait for data, hold the instruction until D takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_BOOT;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      cur_pc     <= RESET_PC;
      pend_pc    <= '0;
      pend_v     <= 1'b0;
      kill       <= 1'b0;
      f_valid    <= 1'b0;
      f_pc       <= RESET_PC;
      f_instr    <= '0;
      f_exc_adel <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_REQ;
          if (flush) begin
            addr_q <= flush_pc;
            req_q  <= fetch_ok(flush_pc);
            pend_v <= 1'b0;
          end else begin
            req_q <= fetch_ok(addr_q);
            if (redir) begin
              pend_pc <= redir_pc;
              pend_v  <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (!req_q) begin
            // Illegal address: no bus cycle, the fault itself is the presented slot.
            if (flush) begin
              addr_q <= flush_pc;
              req_q  <= fetch_ok(flush_pc);
              pend_v <= 1'b0;
            end else begin
              state      <= S_HOLD;
              f_valid    <= 1'b1;
              f_exc_adel <= 1'b1;
              f_instr    <= '0;
              f_pc       <= addr_q;
              addr_q     <= seq_pc;
              pend_v     <= 1'b0;
            end
          end else if (imem.imem_gnt) begin
            state  <= S_WAIT;
            req_q  <= 1'b0;
            cur_pc <= addr_q;
            pend_v <= 1'b0;
            if (flush) begin
              kill   <= 1'b1;
              addr_q <= flush_pc;
            end else begin
              addr_q <= seq_pc;
            end
          end else begin
            // Request must stay stable until granted; targets are queued behind it.
            if (flush) begin
              kill    <= 1'b1;
              pend_pc <= flush_pc;
              pend_v  <= 1'b1;
            end else if (redir) begin
              pend_pc <= redir_pc;
              pend_v  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (flush) begin
              kill   <= 1'b0;
              state  <= S_REQ;
              addr_q <= flush_pc;
              req_q  <= fetch_ok(flush_pc);
            end else if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
              req_q <= fetch_ok(addr_q);
            end else begin
              state      <= S_HOLD;
              f_valid    <= 1'b1;
              f_exc_adel <= 1'b0;
              f_instr    <= imem.imem_rdata;
              f_pc       <= cur_pc;
              if (redir) addr_q <= redir_pc;
            end
          end else if (flush) begin
            kill   <= 1'b1;
            addr_q <= flush_pc;
          end else if (redir) begin
            addr_q <= redir_pc;
          end
        end

        S_HOLD: begin
          if (flush) begin
            state      <= S_REQ;
            f_valid    <= 1'b0;
            f_exc_adel <= 1'b0;
            addr_q     <= flush_pc;
            req_q      <= fetch_ok(flush_pc);
            pend_v     <= 1'b0;
          end else if (!stall) begin
            state      <= S_REQ;
            f_valid    <= 1'b0;
            f_exc_adel <= 1'b0;
            if (redir) begin
              addr_q <= redir_pc;
              req_q  <= fetch_ok(redir_pc);
            end else begin
              req_q <= fetch_ok(addr_q);
            end
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_seq.sv
// tb/tb_f_fetch_seq.sv - randomized bench for f_fetch_seq against a PC-stream reference model
module tb_f_fetch_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] HANDLER  = 32'h0000_4180;
  localparam logic [31:0] LO       = 32'h0000_3000;
  localparam logic [31:0] HI       = 32'h0000_6ffc;
  localparam int          N_CYC    = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exc_adel;

  f_fetch_seq_if bus ();

  f_fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .imem        (bus),
    .f_valid     (f_valid),
    .f_pc        (f_pc),
    .f_instr     (f_instr),
    .f_exc_adel  (f_exc_adel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_imem(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2408_0001 + (a - RESET_PC) * 32'h0001_0003;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 9))
      0:       t = 32'h0000_3000 + ($urandom_range(0, 32'hfff) << 2) + 32'd2;
      1:       t = 32'h0000_6ff8;
      2:       t = 32'h0000_1000;
      3:       t = 32'hffff_fffc;
      default: t = 32'h0000_3000 + ($urandom_range(0, 32'hfff) << 2);
    endcase
    return t;
  endfunction

  // PC-stream model: the PC D must receive next, plus an armed branch target
  // that takes effect after the delay slot.
  logic [31:0] exp_pc;
  logic        armed;
  logic [31:0] tgt;
  logic        d_has;
  logic        ds_in_d;
  int          consumes;

  // Memory model state
  logic        outstanding;
  logic [31:0] out_addr;
  int          out_wait;

  initial begin
    logic        s_req, s_fv, s_adel;
    logic [31:0] s_addr, s_fpc, s_fi;
    logic        hold_chk, req_wait;
    logic [31:0] h_pc, h_instr, w_addr;
    logic        flush, br, redir_ok;
    logic [31:0] flush_pc;

    reset = 1'b0; stall = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = '0;
    redir_valid = 1'b0; redir_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    exp_pc = RESET_PC; armed = 1'b0; tgt = '0; d_has = 1'b0; ds_in_d = 1'b0; consumes = 0;
    outstanding = 1'b0; out_addr = '0; out_wait = 0;
    hold_chk = 1'b0; req_wait = 1'b0; h_pc = '0; h_instr = '0; w_addr = '0;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr",  bus.imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, f_valid}, 32'd0);
    chk("rst_pc",    f_pc, RESET_PC);
    chk("rst_instr", f_instr, 32'd0);
    chk("rst_adel",  {31'd0, f_exc_adel}, 32'd0);
    reset = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      s_req  = bus.imem_req;
      s_addr = bus.imem_addr;
      s_fv   = f_valid;
      s_fpc  = f_pc;
      s_fi   = f_instr;
      s_adel = f_exc_adel;

      if (hold_chk) begin
        chk("hold_valid", {31'd0, s_fv}, 32'd1);
        chk("hold_pc",    s_fpc, h_pc);
        chk("hold_instr", s_fi, h_instr);
      end
      if (req_wait) begin
        chk("req_stable",  {31'd0, s_req}, 32'd1);
        chk("addr_stable", s_addr, w_addr);
      end
      if (s_req) begin
        chk("req_legal",          {31'd0, in_imem(s_addr)}, 32'd1);
        chk("req_while_valid",    {31'd0, s_fv}, 32'd0);
        chk("req_while_inflight", {31'd0, outstanding}, 32'd0);
      end

      stall    = ($urandom_range(0, 9) < 3);
      exc_req  = ($urandom_range(0, 39) == 0);
      eret     = ($urandom_range(0, 39) == 0);
      epc      = pick_target();
      redir_ok = d_has & ~armed & ~ds_in_d;
      if (redir_ok) redir_valid = ($urandom_range(0, 3) == 0);
      else          redir_valid = stall & ($urandom_range(0, 7) == 0);
      redir_pc = pick_target();
      bus.imem_gnt    = s_req & ($urandom_range(0, 9) < 6);
      bus.imem_rvalid = outstanding && (out_wait == 0);
      bus.imem_rdata  = bus.imem_rvalid ? mem_word(out_addr) : $urandom;

      flush    = exc_req | (eret & ~stall);
      flush_pc = exc_req ? HANDLER : epc;
      br       = redir_valid & ~stall & ~exc_req & ~eret;

      if (flush) begin
        exp_pc  = flush_pc;
        armed   = 1'b0;
        d_has   = 1'b0;
        ds_in_d = 1'b0;
      end else if (s_fv && !stall) begin
        consumes++;
        chk("deliver_pc",   s_fpc, exp_pc);
        chk("deliver_adel", {31'd0, s_adel}, {31'd0, ~in_imem(exp_pc)});
        chk("deliver_instr", s_fi, in_imem(exp_pc) ? mem_word(exp_pc) : 32'd0);
        if (br) begin
          exp_pc  = redir_pc;
          ds_in_d = 1'b1;
        end else if (armed) begin
          exp_pc  = tgt;
          armed   = 1'b0;
          ds_in_d = 1'b1;
        end else begin
          exp_pc  = exp_pc + 32'd4;
          ds_in_d = 1'b0;
        end
        d_has = 1'b1;
      end else if (br) begin
        armed = 1'b1;
        tgt   = redir_pc;
      end

      if (bus.imem_rvalid) outstanding = 1'b0;
      else if (outstanding) out_wait--;
      if (s_req && bus.imem_gnt) begin
        outstanding = 1'b1;
        out_addr    = s_addr;
        out_wait    = $urandom_range(0, 3);
      end

      hold_chk = s_fv & stall & ~flush;
      h_pc     = s_fpc;
      h_instr  = s_fi;
      req_wait = s_req & ~bus.imem_gnt;
      w_addr   = s_addr;
    end

    chk("progress", {31'd0, consumes >= 100}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
